// File: rtl/frame_buffer.sv
`timescale 1ns/1ps
// frame_buffer
// Multi-buffered pixel store shared by one writer and one reader. The
// writer fills buffer w_idx and hands it over with swap_req; the reader
// shows buffer r_idx and moves to the next completed buffer on
// rd_frame_end. When no completed buffer is waiting, the reader repeats
// its current frame.
//
// Parameters:
//   DATA_W   - pixel word width
//   ADDR_W   - per-buffer address width (depth 2**ADDR_W)
//   NUM_BUFS - number of buffers, 2..4
//
// Ports:
//   clk           in   sole clock, rising edge
//   rst_n         in   asynchronous active-low reset
//   en            in   global enable; state, memory and outputs hold when low
//   wr_en         in   write strobe
//   wr_addr       in   write address inside the write buffer
//   wr_data       in   write data
//   swap_req      in   writer marks its current buffer complete
//   swap_ack      out  one-cycle pulse, writer now owns a fresh buffer
//   wr_busy       out  writer advance pending, writes are ignored
//   rd_addr       in   read address inside the read buffer
//   rd_frame_end  in   reader finished a frame
//   rd_data       out  registered read data (1-cycle latency)
//   ready_cnt     out  completed buffers not yet shown
//   rd_repeat_cnt out  repeated-frame counter, only with FRAME_BUFFER_REPEAT_CNT_EN
//
// Optional feature macro: FRAME_BUFFER_REPEAT_CNT_EN adds rd_repeat_cnt.
// Memory contents are deliberately not reset.

module frame_buffer #(
  parameter int DATA_W   = 12,
  parameter int ADDR_W   = 10,
  parameter int NUM_BUFS = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              swap_req,
  output logic              swap_ack,
  output logic              wr_busy,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_frame_end,
  output logic [DATA_W-1:0] rd_data,
  output logic [2:0]        ready_cnt
`ifdef FRAME_BUFFER_REPEAT_CNT_EN
  ,
  output logic [15:0]       rd_repeat_cnt
`endif
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int IDX_W = (NUM_BUFS > 2) ? 2 : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BUFS - 1);

  logic [DATA_W-1:0] mem [NUM_BUFS*DEPTH];

  logic [IDX_W-1:0] w_idx;
  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] w_next_s;
  logic [IDX_W-1:0] r_next_s;
  logic             swap_accept_s;
  logic             w_advance_s;
  logic             r_advance_s;
  logic             repeat_s;

  // Next-index arithmetic and the three handshake decisions for this edge.
  always_comb begin
    w_next_s      = w_idx;
    r_next_s      = r_idx;
    swap_accept_s = 1'b0;
    w_advance_s   = 1'b0;
    r_advance_s   = 1'b0;
    repeat_s      = 1'b0;

    if (w_idx == LAST_IDX) begin
      w_next_s = {IDX_W{1'b0}};
    end else begin
      w_next_s = w_idx + IDX_W'(1);
    end

    if (r_idx == LAST_IDX) begin
      r_next_s = {IDX_W{1'b0}};
    end else begin
      r_next_s = r_idx + IDX_W'(1);
    end

    // Accept and advance are mutually exclusive through wr_busy, so a
    // request can never be honoured in its own cycle.
    swap_accept_s = en & swap_req & ~wr_busy;
    // The writer may only move onto a buffer the reader is not showing.
    w_advance_s   = en & wr_busy & (w_next_s != r_idx);
    r_advance_s   = en & rd_frame_end & (ready_cnt != 3'd0);
    repeat_s      = en & rd_frame_end & (ready_cnt == 3'd0);
  end

  // Buffer storage; a write coinciding with swap acceptance still lands in
  // the old buffer because w_idx only moves on a later edge.
  always_ff @(posedge clk) begin
    if (en && wr_en && !wr_busy) begin
      mem[{w_idx, wr_addr}] <= wr_data;
    end else begin
      mem[{w_idx, wr_addr}] <= mem[{w_idx, wr_addr}];
    end
  end

  // Index, handshake, occupancy and read-data registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_idx     <= {IDX_W{1'b0}};
      r_idx     <= LAST_IDX;
      ready_cnt <= 3'd0;
      wr_busy   <= 1'b0;
      swap_ack  <= 1'b0;
      rd_data   <= {DATA_W{1'b0}};
    end else if (en) begin
      rd_data  <= mem[{r_idx, rd_addr}];
      swap_ack <= w_advance_s;

      if (swap_accept_s) begin
        wr_busy <= 1'b1;
      end else if (w_advance_s) begin
        wr_busy <= 1'b0;
      end else begin
        wr_busy <= wr_busy;
      end

      if (w_advance_s) begin
        w_idx <= w_next_s;
      end else begin
        w_idx <= w_idx;
      end

      if (r_advance_s) begin
        r_idx <= r_next_s;
      end else begin
        r_idx <= r_idx;
      end

      // A simultaneous hand-over and consumption cancel out.
      case ({swap_accept_s, r_advance_s})
        2'b10:   ready_cnt <= ready_cnt + 3'd1;
        2'b01:   ready_cnt <= ready_cnt - 3'd1;
        default: ready_cnt <= ready_cnt;
      endcase
    end else begin
      w_idx     <= w_idx;
      r_idx     <= r_idx;
      ready_cnt <= ready_cnt;
      wr_busy   <= wr_busy;
      swap_ack  <= swap_ack;
      rd_data   <= rd_data;
    end
  end

`ifdef FRAME_BUFFER_REPEAT_CNT_EN
  // Saturating count of frames the reader had to show again.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_repeat_cnt <= 16'h0000;
    end else if (repeat_s && (rd_repeat_cnt != 16'hFFFF)) begin
      rd_repeat_cnt <= rd_repeat_cnt + 16'h0001;
    end else begin
      rd_repeat_cnt <= rd_repeat_cnt;
    end
  end
`else
  logic repeat_unused_s;
  // Repeat detection has no consumer in this build.
  always_comb begin
    repeat_unused_s = repeat_s;
  end
`endif

endmodule

// File: tb/tb_frame_buffer.sv
`timescale 1ns/1ps
// tb_frame_buffer
// Directed bench for frame_buffer. Instance a uses NUM_BUFS=2, instance b
// uses NUM_BUFS=3; both share one clock but have their own inputs and reset.
// Inputs change 1 ns after a rising edge and outputs are sampled there too.

module tb_frame_buffer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Instance a: two buffers
  logic        a_rst_n, a_en, a_wr_en, a_swap_req, a_swap_ack, a_wr_busy, a_rd_frame_end;
  logic [9:0]  a_wr_addr, a_rd_addr;
  logic [11:0] a_wr_data, a_rd_data;
  logic [2:0]  a_ready_cnt;
  // Instance b: three buffers
  logic        b_rst_n, b_en, b_wr_en, b_swap_req, b_swap_ack, b_wr_busy, b_rd_frame_end;
  logic [9:0]  b_wr_addr, b_rd_addr;
  logic [11:0] b_wr_data, b_rd_data;
  logic [2:0]  b_ready_cnt;
`ifdef FRAME_BUFFER_REPEAT_CNT_EN
  logic [15:0] a_rd_repeat_cnt, b_rd_repeat_cnt;
`endif

  frame_buffer #(.DATA_W(12), .ADDR_W(10), .NUM_BUFS(2)) dut_a (
    .clk(clk), .rst_n(a_rst_n), .en(a_en), .wr_en(a_wr_en), .wr_addr(a_wr_addr),
    .wr_data(a_wr_data), .swap_req(a_swap_req), .swap_ack(a_swap_ack), .wr_busy(a_wr_busy),
    .rd_addr(a_rd_addr), .rd_frame_end(a_rd_frame_end), .rd_data(a_rd_data),
    .ready_cnt(a_ready_cnt)
`ifdef FRAME_BUFFER_REPEAT_CNT_EN
    , .rd_repeat_cnt(a_rd_repeat_cnt)
`endif
  );

  frame_buffer #(.DATA_W(12), .ADDR_W(10), .NUM_BUFS(3)) dut_b (
    .clk(clk), .rst_n(b_rst_n), .en(b_en), .wr_en(b_wr_en), .wr_addr(b_wr_addr),
    .wr_data(b_wr_data), .swap_req(b_swap_req), .swap_ack(b_swap_ack), .wr_busy(b_wr_busy),
    .rd_addr(b_rd_addr), .rd_frame_end(b_rd_frame_end), .rd_data(b_rd_data),
    .ready_cnt(b_ready_cnt)
`ifdef FRAME_BUFFER_REPEAT_CNT_EN
    , .rd_repeat_cnt(b_rd_repeat_cnt)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    a_rst_n = 1'b0; a_en = 1'b0; a_wr_en = 1'b0; a_wr_addr = 10'd0; a_wr_data = 12'h000;
    a_swap_req = 1'b0; a_rd_addr = 10'd0; a_rd_frame_end = 1'b0;
    b_rst_n = 1'b0; b_en = 1'b0; b_wr_en = 1'b0; b_wr_addr = 10'd0; b_wr_data = 12'h000;
    b_swap_req = 1'b0; b_rd_addr = 10'd0; b_rd_frame_end = 1'b0;
    #3;
    vectors++; if (a_swap_ack !== 1'b0) begin miscompares++; $display("FAIL reset_a_ack: got %b want 0", a_swap_ack); end
    vectors++; if (a_wr_busy !== 1'b0) begin miscompares++; $display("FAIL reset_a_busy: got %b want 0", a_wr_busy); end
    vectors++; if (a_ready_cnt !== 3'd0) begin miscompares++; $display("FAIL reset_a_cnt: got %0d want 0", a_ready_cnt); end
    vectors++; if (a_rd_data !== 12'h000) begin miscompares++; $display("FAIL reset_a_rd: got %h want 000", a_rd_data); end
    vectors++; if (b_ready_cnt !== 3'd0) begin miscompares++; $display("FAIL reset_b_cnt: got %0d want 0", b_ready_cnt); end
    vectors++; if (b_wr_busy !== 1'b0) begin miscompares++; $display("FAIL reset_b_busy: got %b want 0", b_wr_busy); end
`ifdef FRAME_BUFFER_REPEAT_CNT_EN
    vectors++; if (a_rd_repeat_cnt !== 16'h0000) begin miscompares++; $display("FAIL reset_a_rep: got %h want 0000", a_rd_repeat_cnt); end
`endif
    tick();
    a_rst_n = 1'b1; b_rst_n = 1'b1;
    tick();
  endtask

  // Two buffers: w=0 r=1 after reset.
  task automatic test_single_swap();
    a_en = 1'b1;
    a_wr_en = 1'b1; a_wr_addr = 10'd5; a_wr_data = 12'h0AB;
    tick();
    a_wr_en = 1'b0; a_swap_req = 1'b1;
    tick();
    a_swap_req = 1'b0;
    vectors++; if (a_ready_cnt !== 3'd1) begin miscompares++; $display("FAIL swap_cnt_up: got %0d want 1", a_ready_cnt); end
    vectors++; if (a_wr_busy !== 1'b1) begin miscompares++; $display("FAIL swap_busy_set: got %b want 1", a_wr_busy); end
    vectors++; if (a_swap_ack !== 1'b0) begin miscompares++; $display("FAIL swap_no_early_ack: got %b want 0", a_swap_ack); end
    tick();
    vectors++; if (a_swap_ack !== 1'b0) begin miscompares++; $display("FAIL swap_blocked_ack: got %b want 0", a_swap_ack); end
    vectors++; if (a_wr_busy !== 1'b1) begin miscompares++; $display("FAIL swap_blocked_busy: got %b want 1", a_wr_busy); end
    a_rd_frame_end = 1'b1; a_rd_addr = 10'd5;
    tick();
    a_rd_frame_end = 1'b0;
    vectors++; if (a_ready_cnt !== 3'd0) begin miscompares++; $display("FAIL swap_cnt_down: got %0d want 0", a_ready_cnt); end
    vectors++; if (a_swap_ack !== 1'b0) begin miscompares++; $display("FAIL swap_ack_same_edge: got %b want 0", a_swap_ack); end
    tick();
    vectors++; if (a_swap_ack !== 1'b1) begin miscompares++; $display("FAIL swap_ack_pulse: got %b want 1", a_swap_ack); end
    vectors++; if (a_wr_busy !== 1'b0) begin miscompares++; $display("FAIL swap_busy_clr: got %b want 0", a_wr_busy); end
    vectors++; if (a_rd_data !== 12'h0AB) begin miscompares++; $display("FAIL swap_readback: got %h want 0ab", a_rd_data); end
    tick();
    vectors++; if (a_swap_ack !== 1'b0) begin miscompares++; $display("FAIL swap_ack_one_cycle: got %b want 0", a_swap_ack); end
  endtask

  // Now w=1 r=0 ready_cnt=0: frame end must repeat buffer 0.
  task automatic test_repeat_frame();
    a_rd_frame_end = 1'b1;
    tick();
    a_rd_frame_end = 1'b0;
    vectors++; if (a_ready_cnt !== 3'd0) begin miscompares++; $display("FAIL repeat_cnt: got %0d want 0", a_ready_cnt); end
    tick();
    vectors++; if (a_rd_data !== 12'h0AB) begin miscompares++; $display("FAIL repeat_rd: got %h want 0ab", a_rd_data); end
`ifdef FRAME_BUFFER_REPEAT_CNT_EN
    vectors++; if (a_rd_repeat_cnt !== 16'h0001) begin miscompares++; $display("FAIL repeat_counter: got %h want 0001", a_rd_repeat_cnt); end
`endif
  endtask

  // w=1 r=0: write buffer 1, then a write during swap and a write while busy.
  task automatic test_write_while_busy();
    a_wr_en = 1'b1; a_wr_addr = 10'd7; a_wr_data = 12'h111;
    tick();
    a_wr_addr = 10'd8; a_wr_data = 12'h333; a_swap_req = 1'b1;
    tick();
    a_swap_req = 1'b0; a_wr_addr = 10'd7; a_wr_data = 12'h222;
    vectors++; if (a_wr_busy !== 1'b1) begin miscompares++; $display("FAIL busy_set: got %b want 1", a_wr_busy); end
    tick();
    a_wr_en = 1'b0; a_rd_frame_end = 1'b1;
    tick();
    a_rd_frame_end = 1'b0;
    tick();
    vectors++; if (a_swap_ack !== 1'b1) begin miscompares++; $display("FAIL busy_swap_ack: got %b want 1", a_swap_ack); end
    a_rd_addr = 10'd7;
    tick();
    vectors++; if (a_rd_data !== 12'h111) begin miscompares++; $display("FAIL busy_write_ignored: got %h want 111", a_rd_data); end
    a_rd_addr = 10'd8;
    tick();
    vectors++; if (a_rd_data !== 12'h333) begin miscompares++; $display("FAIL write_with_swap: got %h want 333", a_rd_data); end
  endtask

  // w=0 r=1, rd_data=333: nothing may move while en is low.
  task automatic test_enable_hold();
    a_en = 1'b0; a_swap_req = 1'b1; a_rd_frame_end = 1'b1; a_rd_addr = 10'd7;
    tick();
    tick();
    vectors++; if (a_rd_data !== 12'h333) begin miscompares++; $display("FAIL en_hold_rd: got %h want 333", a_rd_data); end
    vectors++; if (a_wr_busy !== 1'b0) begin miscompares++; $display("FAIL en_hold_busy: got %b want 0", a_wr_busy); end
    vectors++; if (a_ready_cnt !== 3'd0) begin miscompares++; $display("FAIL en_hold_cnt: got %0d want 0", a_ready_cnt); end
`ifdef FRAME_BUFFER_REPEAT_CNT_EN
    vectors++; if (a_rd_repeat_cnt !== 16'h0001) begin miscompares++; $display("FAIL en_hold_rep: got %h want 0001", a_rd_repeat_cnt); end
`endif
    a_en = 1'b1; a_swap_req = 1'b0; a_rd_frame_end = 1'b0; a_rd_addr = 10'd8;
  endtask

  // Reset between edges while a swap is pending.
  task automatic test_async_reset();
    a_swap_req = 1'b1;
    tick();
    a_swap_req = 1'b0;
    vectors++; if (a_wr_busy !== 1'b1) begin miscompares++; $display("FAIL arst_pre_busy: got %b want 1", a_wr_busy); end
    #1 a_rst_n = 1'b0;
    #1;
    vectors++; if (a_wr_busy !== 1'b0) begin miscompares++; $display("FAIL arst_busy: got %b want 0", a_wr_busy); end
    vectors++; if (a_ready_cnt !== 3'd0) begin miscompares++; $display("FAIL arst_cnt: got %0d want 0", a_ready_cnt); end
    vectors++; if (a_swap_ack !== 1'b0) begin miscompares++; $display("FAIL arst_ack: got %b want 0", a_swap_ack); end
    vectors++; if (a_rd_data !== 12'h000) begin miscompares++; $display("FAIL arst_rd: got %h want 000", a_rd_data); end
    #1 a_rst_n = 1'b1;
    a_rd_addr = 10'd7;
    tick();
    vectors++; if (a_rd_data !== 12'h111) begin miscompares++; $display("FAIL arst_mem_kept7: got %h want 111", a_rd_data); end
    a_rd_addr = 10'd8;
    tick();
    vectors++; if (a_rd_data !== 12'h333) begin miscompares++; $display("FAIL arst_mem_kept8: got %h want 333", a_rd_data); end
  endtask

  // Three buffers: w=0 r=2 after reset; rd_addr fixed at 3.
  task automatic test_triple_buffer();
    b_en = 1'b1; b_rd_addr = 10'd3;
    b_wr_en = 1'b1; b_wr_addr = 10'd3; b_wr_data = 12'h100;
    tick();
    b_wr_en = 1'b0; b_swap_req = 1'b1;
    tick();
    b_swap_req = 1'b0;
    vectors++; if (b_ready_cnt !== 3'd1) begin miscompares++; $display("FAIL tri_cnt1: got %0d want 1", b_ready_cnt); end
    vectors++; if (b_swap_ack !== 1'b0) begin miscompares++; $display("FAIL tri_ack_early: got %b want 0", b_swap_ack); end
    tick();
    vectors++; if (b_swap_ack !== 1'b1) begin miscompares++; $display("FAIL tri_ack_lat2: got %b want 1", b_swap_ack); end
    b_wr_en = 1'b1; b_wr_data = 12'h101;
    tick();
    b_wr_en = 1'b0; b_swap_req = 1'b1;
    tick();
    vectors++; if (b_ready_cnt !== 3'd2) begin miscompares++; $display("FAIL tri_cnt2: got %0d want 2", b_ready_cnt); end
    tick();
    b_swap_req = 1'b0;
    vectors++; if (b_ready_cnt !== 3'd2) begin miscompares++; $display("FAIL tri_req_ignored: got %0d want 2", b_ready_cnt); end
    tick();
    tick();
    vectors++; if (b_wr_busy !== 1'b1) begin miscompares++; $display("FAIL tri_busy_hold: got %b want 1", b_wr_busy); end
    vectors++; if (b_swap_ack !== 1'b0) begin miscompares++; $display("FAIL tri_no_ack: got %b want 0", b_swap_ack); end
    b_rd_frame_end = 1'b1;
    tick();
    b_rd_frame_end = 1'b0;
    vectors++; if (b_ready_cnt !== 3'd1) begin miscompares++; $display("FAIL tri_cnt_dec: got %0d want 1", b_ready_cnt); end
    vectors++; if (b_wr_busy !== 1'b1) begin miscompares++; $display("FAIL tri_busy_edge: got %b want 1", b_wr_busy); end
    tick();
    vectors++; if (b_swap_ack !== 1'b1) begin miscompares++; $display("FAIL tri_ack2: got %b want 1", b_swap_ack); end
    vectors++; if (b_rd_data !== 12'h100) begin miscompares++; $display("FAIL tri_rd0: got %h want 100", b_rd_data); end
  endtask

  // w=2 r=0 ready_cnt=1: hand-over and consumption on the same edge.
  task automatic test_coincident();
    b_swap_req = 1'b1; b_rd_frame_end = 1'b1;
    b_wr_en = 1'b1; b_wr_data = 12'h102;
    tick();
    b_swap_req = 1'b0; b_rd_frame_end = 1'b0; b_wr_en = 1'b0;
    vectors++; if (b_ready_cnt !== 3'd1) begin miscompares++; $display("FAIL co_cnt: got %0d want 1", b_ready_cnt); end
    vectors++; if (b_wr_busy !== 1'b1) begin miscompares++; $display("FAIL co_busy: got %b want 1", b_wr_busy); end
    tick();
    vectors++; if (b_swap_ack !== 1'b1) begin miscompares++; $display("FAIL co_ack: got %b want 1", b_swap_ack); end
    vectors++; if (b_rd_data !== 12'h101) begin miscompares++; $display("FAIL co_rd1: got %h want 101", b_rd_data); end
    b_rd_frame_end = 1'b1;
    tick();
    b_rd_frame_end = 1'b0;
    vectors++; if (b_ready_cnt !== 3'd0) begin miscompares++; $display("FAIL co_cnt0: got %0d want 0", b_ready_cnt); end
    tick();
    vectors++; if (b_rd_data !== 12'h102) begin miscompares++; $display("FAIL co_rd2: got %h want 102", b_rd_data); end
  endtask

  initial begin
    test_reset();
    test_single_swap();
    test_repeat_frame();
    test_write_while_busy();
    test_enable_hold();
    test_async_reset();
    test_triple_buffer();
    test_coincident();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
